// File: rtl/pdl_adc_scanner_pkg.sv
// Shared constants, scan FSM states and helpers for the paddle ADC scanner.
package pdl_adc_scanner_pkg;

  localparam int unsigned PDL_CHANNELS   = 4;
  localparam logic [7:0]  PDL_CENTRE     = 8'h80;
  localparam int unsigned ADC_FRAME_BITS = 17;
  localparam int unsigned ADC_DATA_FIRST = 7;   // SCLK period carrying B9

  typedef enum logic [1:0] {
    ST_GAP,
    ST_CS_SU,
    ST_SHIFT,
    ST_COMMIT
  } scan_state_t;

  // MOSI bit for a given SCLK period: start, SGL, D2=0, D1, D0, then zeros.
  function automatic logic cmd_bit(input logic [1:0] ch, input logic [4:0] idx);
    logic b;
    case (idx)
      5'd0:    b = 1'b1;
      5'd1:    b = 1'b1;
      5'd2:    b = 1'b0;
      5'd3:    b = ch[1];
      5'd4:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] adc_to_paddle(input logic [9:0] raw, input logic inv);
    logic [7:0] v;
    v = raw[9:2];
    return inv ? (8'd255 - v) : v;
  endfunction

endpackage

// File: rtl/pdl_adc_scanner_spi_adc_xfer.sv
// One MCP3008-style SPI conversion: CS setup, 17 SCLK periods, result handoff.
module spi_adc_xfer
  import pdl_adc_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] ch,
  input  logic       miso,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic       idle,
  output logic       done,
  output logic [9:0] result
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST  = 5'(ADC_FRAME_BITS - 1);
  localparam logic [4:0] BIT_DATA0 = 5'(ADC_DATA_FIRST);

  scan_state_t state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        high_half;
  logic [9:0]  shreg;
  logic        miso_meta;
  logic        miso_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // Each SCLK half is CLK_DIV cycles; MISO is sampled on the edge that raises SCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_GAP;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      high_half <= 1'b0;
      shreg     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_GAP: begin
          if (start) begin
            state   <= ST_CS_SU;
            cs_n    <= 1'b0;
            div_cnt <= '0;
          end
        end
        ST_CS_SU: begin
          if (div_cnt == DIV_LAST) begin
            state     <= ST_SHIFT;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            high_half <= 1'b0;
            mosi      <= cmd_bit(ch, 5'd0);
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!high_half) begin
              sclk      <= 1'b1;
              high_half <= 1'b1;
              if (bit_cnt >= BIT_DATA0)
                shreg <= {shreg[8:0], miso_sync};
            end else begin
              sclk      <= 1'b0;
              high_half <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= ST_COMMIT;
                cs_n  <= 1'b1;
                mosi  <= 1'b0;
                done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                mosi    <= cmd_bit(ch, bit_cnt + 5'd1);
              end
            end
          end
        end
        ST_COMMIT: begin
          state <= ST_GAP;
        end
        default: begin
          state <= ST_GAP;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

  assign idle   = (state == ST_GAP);
  assign result = shreg;

endmodule

// File: rtl/pdl_adc_scanner.sv
// Scans four pot channels over SPI into shadow registers and snapshots them on PTRIG.
module pdl_adc_scanner
  import pdl_adc_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 5,
  parameter int unsigned GAP_TICKS = 100,
  parameter logic [3:0]  INVERT    = 4'b0000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        ptrig,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [3:0]  pdl_start,
  output logic [31:0] pdl_value,
  output logic        scan_done
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
  localparam logic [1:0]  CH_LAST  = 2'(PDL_CHANNELS - 1);

  logic [15:0] gap_cnt;
  logic        xfer_start;
  logic        xfer_idle;
  logic        xfer_done;
  logic [9:0]  xfer_result;
  logic [1:0]  ch;
  logic [7:0]  shadow [PDL_CHANNELS];

  assign xfer_start = xfer_idle && (gap_cnt == GAP_LAST);

  spi_adc_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk    (sys_clk),
    .rst    (reset),
    .start  (xfer_start),
    .ch     (ch),
    .miso   (adc_miso),
    .cs_n   (adc_cs_n),
    .sclk   (adc_sclk),
    .mosi   (adc_mosi),
    .idle   (xfer_idle),
    .done   (xfer_done),
    .result (xfer_result)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (!xfer_idle || xfer_start) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end

  // The snapshot reads shadow before a same-cycle commit lands, so PTRIG
  // coinciding with COMMIT still returns the previous sample.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ch        <= '0;
      pdl_start <= '0;
      for (int unsigned n = 0; n < PDL_CHANNELS; n++) begin
        shadow[n]            <= PDL_CENTRE;
        pdl_value[8*n +: 8]  <= PDL_CENTRE;
      end
    end else begin
      pdl_start <= {4{ptrig}};
      if (ptrig) begin
        for (int unsigned n = 0; n < PDL_CHANNELS; n++)
          pdl_value[8*n +: 8] <= shadow[n];
      end
      if (xfer_done) begin
        shadow[ch] <= adc_to_paddle(xfer_result, INVERT[ch]);
        ch         <= ch + 2'd1;
      end
    end
  end

  assign scan_done = xfer_done && (ch == CH_LAST);

endmodule
